// File: rtl/multicycle_ctrl.sv
// Multicycle LEGv8-subset control unit. It sequences FETCH, DECODE, EXECUTE,
// MEM and WRITEBACK, with a memory-wait watchdog and a sticky FAULT state.
module multicycle_ctrl #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [10:0] opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        imem_req,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg2Loc,
  output logic        branch,
  output logic        memRead,
  output logic        memToReg,
  output logic        memWrite,
  output logic        aluSrc,
  output logic        regWrite,
  output logic [3:0]  aluOp,
  output logic [2:0]  state,
  output logic        retire,
  output logic [15:0] instr_count,
  output logic        fault,
  output logic [1:0]  fault_code
);

  typedef enum logic [2:0] {
    FETCH = 3'd0, DECODE = 3'd1, EXECUTE = 3'd2, MEM = 3'd3, WRITEBACK = 3'd4, FAULT = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    C_ADD, C_SUB, C_AND, C_ORR, C_LDUR, C_STUR, C_CBZ, C_B, C_ILL
  } class_t;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_t        stateQ, stateD;
  class_t        clsQ, clsDec;
  logic [CW-1:0] waitQ, waitD;
  logic [1:0]    codeQ, codeD;
  logic [15:0]   countQ;
  logic          waitExpire;

  assign state       = stateQ;
  assign fault       = (stateQ == FAULT);
  assign fault_code  = codeQ;
  assign instr_count = countQ;
  // The cycle that would be the TIMEOUT_CYCLES-th wait is the timeout cycle;
  // mem_ready high there still counts as completion.
  assign waitExpire  = (waitQ == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    clsDec = C_ILL;
    casez (opcode)
      11'b10001011000: clsDec = C_ADD;
      11'b11001011000: clsDec = C_SUB;
      11'b10001010000: clsDec = C_AND;
      11'b10101010000: clsDec = C_ORR;
      11'b11111000010: clsDec = C_LDUR;
      11'b11111000000: clsDec = C_STUR;
      11'b10110100???: clsDec = C_CBZ;
      11'b000101?????: clsDec = C_B;
      default:         clsDec = C_ILL;
    endcase
  end

  always_comb begin
    stateD   = stateQ;
    waitD    = '0;
    codeD    = codeQ;
    imem_req = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    reg2Loc  = 1'b0;
    branch   = 1'b0;
    memRead  = 1'b0;
    memToReg = 1'b0;
    memWrite = 1'b0;
    aluSrc   = 1'b0;
    regWrite = 1'b0;
    aluOp    = 4'b0000;
    retire   = 1'b0;
    case (stateQ)
      FETCH: begin
        imem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          stateD   = DECODE;
        end else if (waitExpire) begin
          stateD = FAULT;
          codeD  = 2'd2;
        end else begin
          waitD = waitQ + CW'(1);
        end
      end
      DECODE: begin
        if (clsDec == C_ILL) begin
          stateD = FAULT;
          codeD  = 2'd1;
        end else begin
          stateD = EXECUTE;
        end
      end
      EXECUTE: begin
        case (clsQ)
          C_ADD: begin aluOp = 4'b0010; stateD = WRITEBACK; end
          C_SUB: begin aluOp = 4'b0110; stateD = WRITEBACK; end
          C_AND: begin aluOp = 4'b0000; stateD = WRITEBACK; end
          C_ORR: begin aluOp = 4'b0001; stateD = WRITEBACK; end
          C_LDUR: begin aluOp = 4'b0010; aluSrc = 1'b1; stateD = MEM; end
          C_STUR: begin aluOp = 4'b0010; aluSrc = 1'b1; reg2Loc = 1'b1; stateD = MEM; end
          C_CBZ: begin
            aluOp    = 4'b0111;
            reg2Loc  = 1'b1;
            branch   = zero;
            pc_write = zero;
            retire   = 1'b1;
            stateD   = FETCH;
          end
          C_B: begin
            aluOp    = 4'b0010;
            branch   = 1'b1;
            pc_write = 1'b1;
            retire   = 1'b1;
            stateD   = FETCH;
          end
          default: begin
            stateD = FAULT;
            codeD  = 2'd1;
          end
        endcase
      end
      MEM: begin
        memRead  = (clsQ == C_LDUR);
        memWrite = (clsQ != C_LDUR);
        if (mem_ready) begin
          if (clsQ == C_LDUR) begin
            stateD = WRITEBACK;
          end else begin
            retire = 1'b1;
            stateD = FETCH;
          end
        end else if (waitExpire) begin
          stateD = FAULT;
          codeD  = 2'd3;
        end else begin
          waitD = waitQ + CW'(1);
        end
      end
      WRITEBACK: begin
        regWrite = 1'b1;
        memToReg = (clsQ == C_LDUR);
        retire   = 1'b1;
        stateD   = FETCH;
      end
      FAULT: stateD = FAULT;
      default: stateD = FETCH;
    endcase
    // While reset is held, nothing is requested and nothing retires.
    if (!reset_n) begin
      imem_req = 1'b0;
      ir_write = 1'b0;
      pc_write = 1'b0;
      reg2Loc  = 1'b0;
      branch   = 1'b0;
      memRead  = 1'b0;
      memToReg = 1'b0;
      memWrite = 1'b0;
      aluSrc   = 1'b0;
      regWrite = 1'b0;
      aluOp    = 4'b0000;
      retire   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stateQ <= FETCH;
      clsQ   <= C_ILL;
      waitQ  <= '0;
      codeQ  <= 2'd0;
      countQ <= 16'd0;
    end else begin
      stateQ <= stateD;
      waitQ  <= waitD;
      codeQ  <= codeD;
      if (stateQ == DECODE) clsQ <= clsDec;
      if (retire) countQ <= countQ + 16'd1;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle state/control checks across
// every instruction class, memory waits, timeouts, faults, wrap and reset.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] opcode;
  logic        zero;
  logic        mem_ready;
  logic        imem_req, ir_write, pc_write, reg2Loc, branch, memRead;
  logic        memToReg, memWrite, aluSrc, regWrite, retire, fault;
  logic [3:0]  aluOp;
  logic [2:0]  state;
  logic [15:0] instr_count;
  logic [1:0]  fault_code;
  logic [10:0] ctlVec;

  int checks = 0;
  int failures = 0;

  localparam logic [10:0] K_IMEM = 11'b100_0000_0000;
  localparam logic [10:0] K_IRW  = 11'b010_0000_0000;
  localparam logic [10:0] K_PCW  = 11'b001_0000_0000;
  localparam logic [10:0] K_R2L  = 11'b000_1000_0000;
  localparam logic [10:0] K_BR   = 11'b000_0100_0000;
  localparam logic [10:0] K_MRD  = 11'b000_0010_0000;
  localparam logic [10:0] K_M2R  = 11'b000_0001_0000;
  localparam logic [10:0] K_MWR  = 11'b000_0000_1000;
  localparam logic [10:0] K_ASRC = 11'b000_0000_0100;
  localparam logic [10:0] K_RW   = 11'b000_0000_0010;
  localparam logic [10:0] K_RET  = 11'b000_0000_0001;
  localparam logic [10:0] K_FETCH = K_IMEM | K_IRW | K_PCW;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101;
  localparam logic [10:0] OP_B    = 11'b00010110101;

  assign ctlVec = {imem_req, ir_write, pc_write, reg2Loc, branch, memRead,
                   memToReg, memWrite, aluSrc, regWrite, retire};

  multicycle_ctrl #(.TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write), .reg2Loc(reg2Loc),
    .branch(branch), .memRead(memRead), .memToReg(memToReg), .memWrite(memWrite),
    .aluSrc(aluSrc), .regWrite(regWrite), .aluOp(aluOp), .state(state), .retire(retire),
    .instr_count(instr_count), .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inputs are set at edge+1; the cycle is checked at edge+2, then advanced.
  task automatic cyc(input string tag, input logic [2:0] st, input logic [10:0] ctl,
                     input logic [3:0] alu);
    #1;
    check({tag, "/state"}, 16'(state), 16'(st));
    check({tag, "/ctl"},   16'(ctlVec), 16'(ctl));
    check({tag, "/aluOp"}, 16'(aluOp), 16'(alu));
    check({tag, "/fault"}, 16'(fault), 16'(st == 3'd7));
    tick();
  endtask

  task automatic rtype(input string tag, input logic [10:0] op, input logic [3:0] alu);
    opcode = op;
    mem_ready = 1'b1;
    cyc({tag, "-F"}, 3'd0, K_FETCH, 4'b0000);
    cyc({tag, "-D"}, 3'd1, 11'd0, 4'b0000);
    cyc({tag, "-E"}, 3'd2, 11'd0, alu);
    cyc({tag, "-W"}, 3'd4, K_RW | K_RET, 4'b0000);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    #1;
    check("rst/state", 16'(state), 16'd0);
    check("rst/ctl", 16'(ctlVec), 16'd0);
    check("rst/fault", 16'(fault), 16'd0);
    check("rst/code", 16'(fault_code), 16'd0);
    check("rst/count", instr_count, 16'd0);
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    opcode = 11'd0;
    zero = 1'b0;
    mem_ready = 1'b1;
    tick();
    do_reset();

    // ADD: states 0,1,2,4; retire on cycle 4
    opcode = OP_ADD;
    cyc("add-F", 3'd0, K_FETCH, 4'b0000);
    cyc("add-D", 3'd1, 11'd0, 4'b0000);
    cyc("add-E", 3'd2, 11'd0, 4'b0010);
    #1 check("add-W/count-before", instr_count, 16'd0);
    cyc("add-W", 3'd4, K_RW | K_RET, 4'b0000);
    #1 check("add/count", instr_count, 16'd1);

    // LDUR with three not-ready MEM cycles: eight cycles total
    opcode = OP_LDUR;
    cyc("ldur-F", 3'd0, K_FETCH, 4'b0000);
    cyc("ldur-D", 3'd1, 11'd0, 4'b0000);
    cyc("ldur-E", 3'd2, K_ASRC, 4'b0010);
    mem_ready = 1'b0;
    cyc("ldur-M1", 3'd3, K_MRD, 4'b0000);
    cyc("ldur-M2", 3'd3, K_MRD, 4'b0000);
    cyc("ldur-M3", 3'd3, K_MRD, 4'b0000);
    mem_ready = 1'b1;
    cyc("ldur-M4", 3'd3, K_MRD, 4'b0000);
    cyc("ldur-W", 3'd4, K_RW | K_M2R | K_RET, 4'b0000);
    #1 check("ldur/count", instr_count, 16'd2);

    // STUR retires in MEM
    opcode = OP_STUR;
    cyc("stur-F", 3'd0, K_FETCH, 4'b0000);
    cyc("stur-D", 3'd1, 11'd0, 4'b0000);
    cyc("stur-E", 3'd2, K_ASRC | K_R2L, 4'b0010);
    cyc("stur-M", 3'd3, K_MWR | K_RET, 4'b0000);
    #1 check("stur/count", instr_count, 16'd3);

    // CBZ taken then not taken, then unconditional B
    opcode = OP_CBZ;
    zero = 1'b1;
    cyc("cbz1-F", 3'd0, K_FETCH, 4'b0000);
    cyc("cbz1-D", 3'd1, 11'd0, 4'b0000);
    cyc("cbz1-E", 3'd2, K_R2L | K_BR | K_PCW | K_RET, 4'b0111);
    zero = 1'b0;
    cyc("cbz0-F", 3'd0, K_FETCH, 4'b0000);
    cyc("cbz0-D", 3'd1, 11'd0, 4'b0000);
    cyc("cbz0-E", 3'd2, K_R2L | K_RET, 4'b0111);
    opcode = OP_B;
    cyc("b-F", 3'd0, K_FETCH, 4'b0000);
    cyc("b-D", 3'd1, 11'd0, 4'b0000);
    cyc("b-E", 3'd2, K_BR | K_PCW | K_RET, 4'b0010);
    #1 check("branch/count", instr_count, 16'd6);

    rtype("sub", OP_SUB, 4'b0110);
    rtype("and", OP_AND, 4'b0000);
    rtype("orr", OP_ORR, 4'b0001);
    #1 check("rtype/count", instr_count, 16'd9);

    // Fetch ready arrives on the 15th cycle: completion, not fault
    opcode = OP_B;
    mem_ready = 1'b0;
    for (int i = 0; i < 14; i++) cyc("nearmiss-Fw", 3'd0, K_IMEM, 4'b0000);
    mem_ready = 1'b1;
    cyc("nearmiss-F", 3'd0, K_FETCH, 4'b0000);
    cyc("nearmiss-D", 3'd1, 11'd0, 4'b0000);
    cyc("nearmiss-E", 3'd2, K_BR | K_PCW | K_RET, 4'b0010);
    #1 check("nearmiss/count", instr_count, 16'd10);

    // Counter wrap: preload 0xFFFF, next retire gives 0x0000
    dut.countQ = 16'hFFFF;
    cyc("wrap-F", 3'd0, K_FETCH, 4'b0000);
    cyc("wrap-D", 3'd1, 11'd0, 4'b0000);
    #1 check("wrap/count-before", instr_count, 16'hFFFF);
    cyc("wrap-E", 3'd2, K_BR | K_PCW | K_RET, 4'b0010);
    #1 check("wrap/count-after", instr_count, 16'h0000);

    // Reset mid-MEM with mem_ready high: no retire, no count change
    opcode = OP_STUR;
    cyc("rmem-F", 3'd0, K_FETCH, 4'b0000);
    cyc("rmem-D", 3'd1, 11'd0, 4'b0000);
    cyc("rmem-E", 3'd2, K_ASRC | K_R2L, 4'b0010);
    mem_ready = 1'b0;
    cyc("rmem-M", 3'd3, K_MWR, 4'b0000);
    mem_ready = 1'b1;
    reset_n = 1'b0;
    #1;
    check("rmem/retire", 16'(retire), 16'd0);
    check("rmem/memWrite-in", 16'(memWrite), 16'd0);
    tick();
    #1;
    check("rmem/state", 16'(state), 16'd0);
    check("rmem/memWrite", 16'(memWrite), 16'd0);
    check("rmem/count", instr_count, 16'd0);
    tick();
    reset_n = 1'b1;

    // Illegal opcode: FAULT after DECODE, sticky for 20 cycles
    opcode = 11'h000;
    cyc("ill-F", 3'd0, K_FETCH, 4'b0000);
    cyc("ill-D", 3'd1, 11'd0, 4'b0000);
    for (int i = 0; i < 20; i++) begin
      mem_ready = 1'(i);
      zero = 1'(i >> 1);
      opcode = OP_ADD;
      #1 check("ill/code", 16'(fault_code), 16'd1);
      cyc("ill-FAULT", 3'd7, 11'd0, 4'b0000);
    end
    mem_ready = 1'b1;
    do_reset();

    // Fetch stuck low: FAULT code 2 after 15 waits
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) cyc("fto-Fw", 3'd0, K_IMEM, 4'b0000);
    #1 check("fto/code", 16'(fault_code), 16'd2);
    cyc("fto-FAULT", 3'd7, 11'd0, 4'b0000);
    mem_ready = 1'b1;
    cyc("fto-FAULT2", 3'd7, 11'd0, 4'b0000);
    do_reset();

    // MEM stuck low: FAULT code 3
    opcode = OP_STUR;
    cyc("mto-F", 3'd0, K_FETCH, 4'b0000);
    cyc("mto-D", 3'd1, 11'd0, 4'b0000);
    cyc("mto-E", 3'd2, K_ASRC | K_R2L, 4'b0010);
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) cyc("mto-Mw", 3'd3, K_MWR, 4'b0000);
    #1 check("mto/code", 16'(fault_code), 16'd3);
    cyc("mto-FAULT", 3'd7, 11'd0, 4'b0000);
    #1 check("mto/count", instr_count, 16'd0);
    mem_ready = 1'b1;
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL take parameter TIMEOUT_CYCLES, default 15: maximum wait cycles for mem_ready in FETCH or MEM before faulting.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port opcode  input  11  instr[31:21] from the decoder, sampled in DECODE.
REQ-005 SHALL have port zero  input  1  ALU zero flag, sampled in EXECUTE.
REQ-006 SHALL have port mem_ready  input  1  memory completion for the current imem_req/memRead/memWrite access.
REQ-007 SHALL have ports imem_req, ir_write, pc_write  output  1 each  fetch request, instruction-register load, PC update.
REQ-008 SHALL have ports reg2Loc, branch, memRead, memToReg, memWrite, aluSrc, regWrite  output  1 each  datapath controls.
REQ-009 SHALL have port aluOp  output  4  ALU operation.
REQ-010 SHALL have ports state  output  3, retire  output  1, instr_count  output  16, fault  output  1, fault_code  output  2.

Function
REQ-011 SHALL implement states FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, FAULT=7, with state equal to the current state.
REQ-012 SHALL decode classes: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, LDUR 11111000010, STUR 11111000000, CBZ 10110100xxx, B 000101xxxxx; any other opcode is illegal.
REQ-013 SHALL register the decoded class in DECODE and hold it until the next DECODE.
REQ-014 SHALL, in FETCH, assert imem_req and stay until mem_ready; in the mem_ready cycle assert ir_write and pc_write for exactly one cycle, then go to DECODE.
REQ-015 SHALL leave DECODE after one cycle: to FAULT with fault_code=1 if illegal, otherwise to EXECUTE.
REQ-016 SHALL, in EXECUTE, drive aluOp: ADD 0010, SUB 0110, AND 0000, ORR 0001, LDUR/STUR 0010, CBZ 0111; B 0010.
REQ-017 SHALL assert aluSrc in EXECUTE for LDUR/STUR and reg2Loc for STUR/CBZ.
REQ-018 SHALL, for CBZ, pulse branch and pc_write in EXECUTE only if zero=1; for B, pulse both unconditionally.
REQ-019 SHALL route CBZ/B to FETCH, LDUR/STUR to MEM, and R-type to WRITEBACK.
REQ-020 SHALL, in MEM, hold memRead (LDUR) or memWrite (STUR) until mem_ready, then go to WRITEBACK for LDUR or FETCH for STUR.
REQ-021 SHALL, in WRITEBACK, assert regWrite for one cycle, with memToReg=1 only for LDUR, then go to FETCH.
REQ-022 SHALL pulse retire for one cycle on the final cycle of each instruction (EXECUTE for CBZ/B, MEM for STUR, WRITEBACK otherwise) and increment instr_count modulo 2^16 in the same cycle; 0xFFFF wraps to 0x0000.
REQ-023 SHALL count consecutive FETCH/MEM cycles with mem_ready=0, cleared on state entry; on reaching TIMEOUT_CYCLES go to FAULT with fault_code=2 (FETCH) or 3 (MEM).
REQ-024 SHALL treat mem_ready=1 on the timeout cycle as completion, with no fault.
REQ-025 SHALL keep FAULT sticky with fault=1, fault_code held, and all datapath controls 0, until reset.
REQ-026 SHALL deassert every control output not explicitly asserted by the current state, with aluOp=0000 outside EXECUTE.
REQ-027 SHALL give minimum latencies of R-type 4, LDUR 5, STUR 4, CBZ/B 3 cycles with mem_ready tied high.

Reset
REQ-028 SHALL, on a clock edge with reset_n=0, set state=FETCH, clear all controls, set retire=0, instr_count=0, fault=0, fault_code=0 and the wait counter to 0.
REQ-029 SHALL let reset override any state, including FAULT and mid-MEM, with no retire pulse and no count change.
REQ-030 SHALL begin FETCH on the first edge after reset_n returns to 1.

Verification
REQ-031 SHALL verify: ADD opcode, mem_ready=1 -> states 0,1,2,4; aluOp=0010 in EXECUTE; regWrite for one cycle; retire on cycle 4; instr_count=1.
REQ-032 SHALL verify: LDUR with mem_ready low 3 cycles in MEM -> memRead held 4 cycles, WRITEBACK with memToReg=1, total 8 cycles.
REQ-033 SHALL verify: CBZ with zero=1 then zero=0 -> branch and pc_write pulse only for the first; each takes 3 cycles.
REQ-034 SHALL verify: opcode 0x000 -> FAULT after DECODE, fault_code=1, all controls 0 for 20 cycles, cleared by reset.
REQ-035 SHALL verify: mem_ready stuck low in FETCH -> FAULT, fault_code=2, after 15 waits; ready arriving on wait 15 -> no fault.
REQ-036 SHALL verify: preload via 65535 retires -> next retire wraps instr_count to 0; reset_n=0 mid-MEM -> FETCH next edge, memWrite=0.
